// File: rtl/data_bus_ctrl.sv
// Data-bus slave for the RV32 memory stage: word RAM, GPIO and a compare timer.
// Reads are combinational; writes commit on the rising edge of CLOCK.
module data_bus_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] ram_address,
    input  logic [WIDTH-1:0] ram_w_data,
    input  logic             Read_Write_ram_en,
    output logic [WIDTH-1:0] ram_r_data,
    input  logic [7:0]       gpio_in,
    output logic [7:0]       gpio_out,
    output logic             timer_irq,
    output logic             bus_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [WIDTH-1:0] ADDR_GPIO_OUT = WIDTH'(32'h8000_0000);
    localparam logic [WIDTH-1:0] ADDR_GPIO_IN  = WIDTH'(32'h8000_0004);
    localparam logic [WIDTH-1:0] ADDR_COUNT    = WIDTH'(32'h8000_0008);
    localparam logic [WIDTH-1:0] ADDR_CMP      = WIDTH'(32'h8000_000C);
    localparam logic [WIDTH-1:0] ADDR_CTRL     = WIDTH'(32'h8000_0010);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [7:0]       gpio_sync1;
    logic [7:0]       gpio_sync2;
    logic [WIDTH-1:0] timer_count;
    logic [WIDTH-1:0] timer_cmp;
    logic             timer_en;
    logic             timer_autoreload;
    logic             timer_flag;

    logic             aligned;
    logic             hit_ram;
    logic             hit_gpio_out;
    logic             hit_gpio_in;
    logic             hit_count;
    logic             hit_cmp;
    logic             hit_ctrl;
    logic [AW-1:0]    word_idx;
    logic             wr_ok;
    logic             wr_ram;
    logic             timer_match;

    assign aligned      = (ram_address[1:0] == 2'b00);
    assign hit_ram      = (ram_address[WIDTH-1:AW+2] == '0);
    assign word_idx     = ram_address[AW+1:2];
    assign hit_gpio_out = (ram_address == ADDR_GPIO_OUT);
    assign hit_gpio_in  = (ram_address == ADDR_GPIO_IN);
    assign hit_count    = (ram_address == ADDR_COUNT);
    assign hit_cmp      = (ram_address == ADDR_CMP);
    assign hit_ctrl     = (ram_address == ADDR_CTRL);

    // GPIO_IN is deliberately absent: a store there is an error, not a no-op.
    assign wr_ok = Read_Write_ram_en &&
                   ((aligned && hit_ram) || hit_gpio_out || hit_count || hit_cmp || hit_ctrl);

    // RAM has no reset, so the write must be gated explicitly while RESET is low.
    assign wr_ram      = wr_ok && hit_ram && RESET;
    assign timer_match = timer_en && (timer_count == timer_cmp);
    assign timer_irq   = timer_flag;

    always_ff @(posedge CLOCK) begin
        if (wr_ram) begin
            mem[word_idx] <= ram_w_data;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            gpio_out         <= '0;
            gpio_sync1       <= '0;
            gpio_sync2       <= '0;
            timer_count      <= '0;
            timer_cmp        <= '1;
            timer_en         <= 1'b0;
            timer_autoreload <= 1'b0;
            timer_flag       <= 1'b0;
            bus_err          <= 1'b0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            bus_err    <= Read_Write_ram_en && !wr_ok;

            if (wr_ok && hit_gpio_out) begin
                gpio_out <= ram_w_data[7:0];
            end

            if (wr_ok && hit_count) begin
                timer_count <= ram_w_data;
            end else if (timer_en) begin
                timer_count <= (timer_match && timer_autoreload) ? '0 : timer_count + WIDTH'(1);
            end

            if (wr_ok && hit_cmp) begin
                timer_cmp <= ram_w_data;
            end

            if (wr_ok && hit_ctrl) begin
                timer_en         <= ram_w_data[0];
                timer_autoreload <= ram_w_data[1];
            end

            // A match in the same cycle as a write-1-to-clear keeps the flag set.
            if (timer_match) begin
                timer_flag <= 1'b1;
            end else if (wr_ok && hit_ctrl && ram_w_data[2]) begin
                timer_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        ram_r_data = '0;
        if (hit_ram) begin
            ram_r_data = mem[word_idx];
        end else if (hit_gpio_out) begin
            ram_r_data = {{(WIDTH-8){1'b0}}, gpio_out};
        end else if (hit_gpio_in) begin
            ram_r_data = {{(WIDTH-8){1'b0}}, gpio_sync2};
        end else if (hit_count) begin
            ram_r_data = timer_count;
        end else if (hit_cmp) begin
            ram_r_data = timer_cmp;
        end else if (hit_ctrl) begin
            ram_r_data = {{(WIDTH-3){1'b0}}, timer_flag, timer_autoreload, timer_en};
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: directed vector table, hand-written timer/reset
// sequences, then random traffic checked against a behavioural model.
module tb_data_bus_ctrl;

    localparam int DEPTH = 256;
    localparam logic [31:0] RAM_TOP   = 32'(4 * DEPTH);
    localparam logic [31:0] A_GPIO_O  = 32'h8000_0000;
    localparam logic [31:0] A_GPIO_I  = 32'h8000_0004;
    localparam logic [31:0] A_COUNT   = 32'h8000_0008;
    localparam logic [31:0] A_CMP     = 32'h8000_000C;
    localparam logic [31:0] A_CTRL    = 32'h8000_0010;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] ram_address;
    logic [31:0] ram_w_data;
    logic        Read_Write_ram_en;
    logic [31:0] ram_r_data;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    logic        bus_err;

    data_bus_ctrl #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .CLOCK             (CLOCK),
        .RESET             (RESET),
        .ram_address       (ram_address),
        .ram_w_data        (ram_w_data),
        .Read_Write_ram_en (Read_Write_ram_en),
        .ram_r_data        (ram_r_data),
        .gpio_in           (gpio_in),
        .gpio_out          (gpio_out),
        .timer_irq         (timer_irq),
        .bus_err           (bus_err)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model of the visible register/RAM state.
    logic [31:0] m_ram [int];
    logic [7:0]  m_gpio;
    logic [7:0]  m_s1, m_s2;
    logic [31:0] m_count, m_cmp;
    bit          m_en, m_ar, m_flag, m_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        bit          we;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ram.delete();
        m_gpio = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
        m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
        m_en = 1'b0; m_ar = 1'b0; m_flag = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        known = 1'b1;
        v = 32'h0;
        if (a < RAM_TOP) begin
            if (a[1:0] != 2'b00 || !m_ram.exists(int'(a >> 2))) known = 1'b0;
            else v = m_ram[int'(a >> 2)];
        end else if (a == A_GPIO_O) v = {24'h0, m_gpio};
        else if (a == A_GPIO_I) v = {24'h0, m_s2};
        else if (a == A_COUNT)  v = m_count;
        else if (a == A_CMP)    v = m_cmp;
        else if (a == A_CTRL)   v = {29'h0, m_flag, m_ar, m_en};
    endtask

    task automatic model_update(input logic [31:0] a, input logic [31:0] wd, input bit we,
                                input logic [7:0] gin);
        bit          legal, match, clr;
        logic [31:0] nc;
        legal = (a[1:0] == 2'b00) &&
                (a < RAM_TOP || a == A_GPIO_O || a == A_COUNT || a == A_CMP || a == A_CTRL);
        match = m_en && (m_count == m_cmp);
        nc = m_count;
        if (m_en) nc = (match && m_ar) ? 32'h0 : m_count + 32'h1;
        clr = 1'b0;
        if (we && legal) begin
            if (a < RAM_TOP)       m_ram[int'(a >> 2)] = wd;
            else if (a == A_GPIO_O) m_gpio = wd[7:0];
            else if (a == A_COUNT)  nc = wd;
            else if (a == A_CMP)    m_cmp = wd;
            else begin
                m_en = wd[0];
                m_ar = wd[1];
                clr  = wd[2];
            end
        end
        m_count = nc;
        if (match) m_flag = 1'b1;
        else if (clr) m_flag = 1'b0;
        m_err = we && !legal;
        m_s2 = m_s1;
        m_s1 = gin;
    endtask

    // One bus cycle: drive at negedge, sample read data before the edge, update model on the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input bit we,
                        output logic [31:0] rd);
        @(negedge CLOCK);
        ram_address = a;
        ram_w_data = wd;
        Read_Write_ram_en = we;
        #1;
        rd = ram_r_data;
        @(posedge CLOCK);
        model_update(a, wd, we, gpio_in);
        #1;
        Read_Write_ram_en = 1'b0;
    endtask

    task automatic chk_model_outs(input string tag);
        chk({tag, " gpio_out"}, {24'h0, gpio_out}, {24'h0, m_gpio});
        chk({tag, " timer_irq"}, {31'h0, timer_irq}, {31'h0, m_flag});
        chk({tag, " bus_err"}, {31'h0, bus_err}, {31'h0, m_err});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, ev, a, wd;
        bit          known, we;
        logic [31:0] exp_cnt [5];

        RESET = 1'b0;
        ram_address = 32'h0;
        ram_w_data = 32'h0;
        Read_Write_ram_en = 1'b0;
        gpio_in = 8'h00;
        model_reset();

        // Reset state
        #12;
        chk("rst gpio_out", {24'h0, gpio_out}, 32'h0);
        chk("rst timer_irq", {31'h0, timer_irq}, 32'h0);
        chk("rst bus_err", {31'h0, bus_err}, 32'h0);
        ram_address = A_COUNT; #1; chk("rst count", ram_r_data, 32'h0);
        ram_address = A_CMP;   #1; chk("rst cmp", ram_r_data, 32'hFFFF_FFFF);
        ram_address = A_CTRL;  #1; chk("rst ctrl", ram_r_data, 32'h0);
        ram_address = A_GPIO_I; #1; chk("rst gpio_in", ram_r_data, 32'h0);
        @(negedge CLOCK);
        RESET = 1'b1;

        // Directed table
        vt.push_back('{32'h0000_0000, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0,         1'b0, 8'h00});
        vt.push_back('{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b0, 8'h00});
        vt.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00});
        vt.push_back('{32'h0000_0010, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00});
        vt.push_back('{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 8'h00});
        vt.push_back('{32'h0000_03FC, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         1'b0, 8'h00});
        vt.push_back('{32'h0000_03FC, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h00});
        vt.push_back('{32'h0000_0400, 32'h1111_1111, 1'b1, 1'b1, 32'h0,         1'b1, 8'h00});
        vt.push_back('{32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 8'h00});
        vt.push_back('{32'h0000_0002, 32'h2222_2222, 1'b1, 1'b0, 32'h0,         1'b1, 8'h00});
        vt.push_back('{32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 8'h00});
        vt.push_back('{A_GPIO_O,      32'h0000_01A5, 1'b1, 1'b1, 32'h0,         1'b0, 8'hA5});
        vt.push_back('{A_GPIO_O,      32'h0,         1'b0, 1'b1, 32'h0000_00A5, 1'b0, 8'hA5});
        vt.push_back('{A_GPIO_I,      32'h0000_00FF, 1'b1, 1'b1, 32'h0,         1'b1, 8'hA5});
        vt.push_back('{A_GPIO_I,      32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'hA5});
        vt.push_back('{32'h8000_0014, 32'h1,         1'b1, 1'b1, 32'h0,         1'b1, 8'hA5});
        vt.push_back('{32'h8000_0014, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'hA5});
        vt.push_back('{32'h8000_0002, 32'h1,         1'b1, 1'b1, 32'h0,         1'b1, 8'hA5});
        vt.push_back('{A_GPIO_O,      32'h0,         1'b0, 1'b1, 32'h0000_00A5, 1'b0, 8'hA5});

        foreach (vt[i]) begin
            step(vt[i].addr, vt[i].wd, vt[i].we, rd);
            if (vt[i].chk_rd) chk($sformatf("vec%0d rd", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d bus_err", i), {31'h0, bus_err}, {31'h0, vt[i].exp_err});
            chk($sformatf("vec%0d gpio_out", i), {24'h0, gpio_out}, {24'h0, vt[i].exp_gpio});
        end

        // gpio_in reaches GPIO_IN two edges after it changes
        gpio_in = 8'h3C;
        step(A_GPIO_I, 32'h0, 1'b0, rd); chk("sync edge0", rd, 32'h0);
        step(A_GPIO_I, 32'h0, 1'b0, rd); chk("sync edge1", rd, 32'h0);
        step(A_GPIO_I, 32'h0, 1'b0, rd); chk("sync edge2", rd, 32'h3C);

        // Timer with autoreload: COUNT 0,1,2,3,0 and flag after the match
        step(A_CMP,   32'h3, 1'b1, rd);
        step(A_COUNT, 32'h0, 1'b1, rd);
        step(A_CTRL,  32'h3, 1'b1, rd);
        exp_cnt = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0};
        for (int i = 0; i < 5; i++) begin
            step(A_COUNT, 32'h0, 1'b0, rd);
            chk($sformatf("ar count%0d", i), rd, exp_cnt[i]);
            chk($sformatf("ar irq%0d", i), {31'h0, timer_irq}, (i >= 3) ? 32'h1 : 32'h0);
        end
        step(A_CTRL, 32'h7, 1'b1, rd);
        chk("ar ctrl read", rd, 32'h7);
        chk("ar w1c irq", {31'h0, timer_irq}, 32'h0);
        step(A_COUNT, 32'h0, 1'b0, rd);
        chk("ar count pre", rd, 32'h2);
        step(A_CTRL, 32'h7, 1'b1, rd);
        chk("ar ctrl pre", rd, 32'h3);
        chk("ar set beats clr", {31'h0, timer_irq}, 32'h1);
        step(A_CTRL, 32'h4, 1'b1, rd);
        chk("ar clr+stop irq", {31'h0, timer_irq}, 32'h0);

        // Timer wrap and COUNT write priority
        step(A_CMP,   32'h5,         1'b1, rd);
        step(A_COUNT, 32'hFFFF_FFFE, 1'b1, rd);
        step(A_CTRL,  32'h1,         1'b1, rd);
        exp_cnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};
        for (int i = 0; i < 4; i++) begin
            step(A_COUNT, 32'h0, 1'b0, rd);
            chk($sformatf("wrap count%0d", i), rd, exp_cnt[i]);
        end
        step(A_COUNT, 32'h100, 1'b1, rd);
        chk("wrap count pre-load", rd, 32'h2);
        step(A_COUNT, 32'h0, 1'b0, rd); chk("load priority", rd, 32'h100);
        step(A_COUNT, 32'h0, 1'b0, rd); chk("after load", rd, 32'h101);
        chk("wrap irq", {31'h0, timer_irq}, 32'h0);

        // Reset mid-operation
        step(A_COUNT, 32'h0, 1'b1, rd);
        step(A_CMP,   32'h1, 1'b1, rd);
        step(A_CTRL,  32'h3, 1'b1, rd);
        step(A_COUNT, 32'h0, 1'b0, rd);
        step(A_COUNT, 32'h0, 1'b0, rd);
        chk("pre-rst irq", {31'h0, timer_irq}, 32'h1);
        chk("pre-rst gpio", {24'h0, gpio_out}, 32'hA5);
        @(negedge CLOCK);
        #1;
        RESET = 1'b0;
        ram_address = A_COUNT;
        #1;
        chk("async gpio_out", {24'h0, gpio_out}, 32'h0);
        chk("async irq", {31'h0, timer_irq}, 32'h0);
        chk("async count", ram_r_data, 32'h0);
        ram_address = A_CMP; #1; chk("async cmp", ram_r_data, 32'hFFFF_FFFF);
        ram_address = A_CTRL; #1; chk("async ctrl", ram_r_data, 32'h0);
        model_reset();
        gpio_in = 8'h00;
        ram_address = A_GPIO_O;
        ram_w_data = 32'hFF;
        Read_Write_ram_en = 1'b1;
        @(posedge CLOCK);
        #1;
        chk("write in reset gpio", {24'h0, gpio_out}, 32'h0);
        chk("write in reset err", {31'h0, bus_err}, 32'h0);
        @(negedge CLOCK);
        Read_Write_ram_en = 1'b0;
        RESET = 1'b1;
        step(A_GPIO_O, 32'h5A, 1'b1, rd);
        chk("first write after rst", {24'h0, gpio_out}, 32'h5A);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            wd = $urandom;
            case ($urandom_range(0, 9))
                0, 1: a = 32'($urandom_range(0, 15)) * 32'd4;
                2:    a = RAM_TOP - 32'd4 - 32'($urandom_range(0, 3)) * 32'd4;
                3:    a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
                4:    a = A_GPIO_O;
                5:    a = A_GPIO_I;
                6:    begin a = A_COUNT; wd = 32'($urandom_range(0, 12)); end
                7:    begin a = A_CMP;   wd = 32'($urandom_range(0, 12)); end
                8:    begin a = A_CTRL;  wd = 32'($urandom_range(0, 7)); end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = RAM_TOP + 32'($urandom_range(0, 255)) * 32'd4;
                        1: a = 32'h8000_0014 + 32'($urandom_range(0, 7)) * 32'd4;
                        2: a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
                        default: a = $urandom;
                    endcase
                end
            endcase
            we = ($urandom_range(0, 2) == 0);
            model_read(a, ev, known);
            step(a, wd, we, rd);
            if (known) chk($sformatf("rnd%0d rd @%h", n, a), rd, ev);
            chk_model_outs($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
